// File: rtl/mlp_infer.sv
// Sequential two-layer MLP inference engine: one signed MAC per cycle, saturating neurons, ReLU hidden layer.
// Optional macro MLP_OUT_RELU_EN applies ReLU to the output layer as well.
module mlp_infer #(
  parameter int IN_SIZE       = 2,
  parameter int HIDDEN_SIZE   = 2,
  parameter int OUT_SIZE      = 1,
  parameter int BITS_PER_WORD = 8,
  parameter int ACC_BITS      = 20,
  localparam int L1_N = HIDDEN_SIZE * (IN_SIZE + 1),
  localparam int NW   = L1_N + OUT_SIZE * (HIDDEN_SIZE + 1),
  localparam int AW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              w_wr_en,
  input  logic [AW-1:0]                     w_addr,
  input  logic [BITS_PER_WORD-1:0]          w_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_SIZE*BITS_PER_WORD-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_SIZE*BITS_PER_WORD-1:0] out_data,
  output logic                              busy
);

  // state  | meaning
  // IDLE   | accepts weight writes and a new input vector
  // L1     | issuing hidden-layer MACs (bias term first per neuron)
  // L2     | issuing output-layer MACs, then draining the last product
  // HOLD   | result presented until out_ready

  localparam int B    = BITS_PER_WORD;
  localparam int P    = 2 * B;
  localparam int CW   = AW + 1;
  localparam int MAXT = (IN_SIZE > HIDDEN_SIZE) ? IN_SIZE : HIDDEN_SIZE;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int MAXN = (HIDDEN_SIZE > OUT_SIZE) ? HIDDEN_SIZE : OUT_SIZE;
  localparam int NWD  = $clog2(MAXN + 1);
  localparam logic signed [ACC_BITS-1:0] SAT_HI = ACC_BITS'((1 << (B - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_HOLD} state_t;
  state_t state_q, state_d;

  logic signed [B-1:0]        wmem  [NW];
  logic signed [B-1:0]        in_q  [IN_SIZE];
  logic signed [B-1:0]        hid_q [HIDDEN_SIZE];
  logic [OUT_SIZE*B-1:0]      out_q;
  logic [CW-1:0]              addr_q;
  logic [TW-1:0]              term_q;
  logic [NWD-1:0]             neu_q;
  logic signed [P-1:0]        prod_q, prod_d;
  logic                       pv_q, plast_q, pl2_q;
  logic [NWD-1:0]             pneu_q;
  logic signed [ACC_BITS-1:0] acc_q, acc_sum;
  logic signed [B-1:0]        w_cur, x_cur, sat_val, hid_val, out_val;
  logic                       issue, last_term, accept, fin;

  assign accept    = (state_q == S_IDLE) && in_valid;
  assign issue     = (state_q == S_L1) || ((state_q == S_L2) && (addr_q < CW'(NW)));
  assign last_term = (state_q == S_L1) ? (term_q == TW'(IN_SIZE)) : (term_q == TW'(HIDDEN_SIZE));
  assign fin       = pv_q && plast_q && pl2_q && (pneu_q == NWD'(OUT_SIZE - 1));

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < NW; k++)
      if (addr_q == CW'(k)) w_cur = wmem[k];
    // Bias terms multiply by a constant 1
    x_cur = {{(B-1){1'b0}}, 1'b1};
    for (int k = 0; k < IN_SIZE; k++)
      if (state_q == S_L1 && term_q == TW'(k + 1)) x_cur = in_q[k];
    for (int k = 0; k < HIDDEN_SIZE; k++)
      if (state_q == S_L2 && term_q == TW'(k + 1)) x_cur = hid_q[k];
    prod_d  = $signed({{B{w_cur[B-1]}}, w_cur}) * $signed({{B{x_cur[B-1]}}, x_cur});
    acc_sum = acc_q + $signed({{(ACC_BITS-P){prod_q[P-1]}}, prod_q});
    if (acc_sum > SAT_HI)      sat_val = {1'b0, {(B-1){1'b1}}};
    else if (acc_sum < SAT_LO) sat_val = {1'b1, {(B-1){1'b0}}};
    else                       sat_val = acc_sum[B-1:0];
    hid_val = sat_val[B-1] ? '0 : sat_val;
`ifdef MLP_OUT_RELU_EN
    out_val = sat_val[B-1] ? '0 : sat_val;
`else
    out_val = sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_L1;
      S_L1:   if (last_term && neu_q == NWD'(HIDDEN_SIZE - 1)) state_d = S_L2;
      S_L2:   if (fin) state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NW; k++) wmem[k] <= '0;
      for (int k = 0; k < IN_SIZE; k++) in_q[k] <= '0;
      for (int k = 0; k < HIDDEN_SIZE; k++) hid_q[k] <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      term_q  <= '0;
      neu_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      plast_q <= 1'b0;
      pl2_q   <= 1'b0;
      pneu_q  <= '0;
      acc_q   <= '0;
    end else begin
      if (state_q == S_IDLE && w_wr_en && ({1'b0, w_addr} < CW'(NW)))
        wmem[w_addr] <= w_data;
      if (accept) begin
        for (int k = 0; k < IN_SIZE; k++) in_q[k] <= in_data[k*B +: B];
        addr_q <= '0;
        term_q <= '0;
        neu_q  <= '0;
        acc_q  <= '0;
      end
      pv_q <= issue;
      if (issue) begin
        prod_q  <= prod_d;
        plast_q <= last_term;
        pl2_q   <= (state_q == S_L2);
        pneu_q  <= neu_q;
        addr_q  <= addr_q + CW'(1);
        if (last_term) begin
          term_q <= '0;
          if (state_q == S_L1 && neu_q == NWD'(HIDDEN_SIZE - 1)) neu_q <= '0;
          else                                                    neu_q <= neu_q + NWD'(1);
        end else begin
          term_q <= term_q + TW'(1);
        end
      end
      // Products land one cycle after issue; the neuron closes on its last term
      if (pv_q) begin
        if (plast_q) begin
          acc_q <= '0;
          for (int k = 0; k < HIDDEN_SIZE; k++)
            if (!pl2_q && pneu_q == NWD'(k)) hid_q[k] <= hid_val;
          for (int k = 0; k < OUT_SIZE; k++)
            if (pl2_q && pneu_q == NWD'(k)) out_q[k*B +: B] <= out_val;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_mlp_infer.sv
// Self-checking bench for mlp_infer: directed XOR/saturation/handshake/reset cases plus random weights and inputs
// checked against an arithmetic reference model.
module tb_mlp_infer;
  localparam int IN   = 2;
  localparam int HID  = 2;
  localparam int OUTN = 1;
  localparam int B    = 8;
  localparam int ACC  = 20;
  localparam int L1N  = HID * (IN + 1);
  localparam int NW   = L1N + OUTN * (HID + 1);
  localparam int AW   = $clog2(NW);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              w_wr_en = 1'b0;
  logic [AW-1:0]     w_addr = '0;
  logic [B-1:0]      w_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN*B-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUTN*B-1:0] out_data;
  logic              busy;

  mlp_infer #(.IN_SIZE(IN), .HIDDEN_SIZE(HID), .OUT_SIZE(OUTN), .BITS_PER_WORD(B), .ACC_BITS(ACC)) dut (
    .clk(clk), .reset_n(reset_n), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int wm [NW];
  int xin [IN];
  int exp_o [OUTN];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    int hi = (1 << (B - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic void model();
    int h [HID];
    int s;
    for (int j = 0; j < HID; j++) begin
      s = wm[j*(IN+1)];
      for (int i = 0; i < IN; i++) s += wm[j*(IN+1) + i + 1] * xin[i];
      h[j] = (sat(s) < 0) ? 0 : sat(s);
    end
    for (int k = 0; k < OUTN; k++) begin
      s = wm[L1N + k*(HID+1)];
      for (int i = 0; i < HID; i++) s += wm[L1N + k*(HID+1) + i + 1] * h[i];
      exp_o[k] = sat(s);
`ifdef MLP_OUT_RELU_EN
      if (exp_o[k] < 0) exp_o[k] = 0;
`endif
    end
  endfunction

  function automatic int dut_out(input int k);
    logic signed [B-1:0] v;
    v = out_data[k*B +: B];
    return int'(v);
  endfunction

  // Called at a falling edge while the DUT is idle
  task automatic write_w(input int a, input int d);
    w_wr_en = 1'b1;
    w_addr  = AW'(a);
    w_data  = B'(d);
    @(negedge clk);
    w_wr_en = 1'b0;
    if (a < NW) wm[a] = d;
  endtask

  task automatic set_x(input int a, input int b);
    xin[0] = a;
    xin[1] = b;
  endtask

  // mode: 0 plain, 1 weight write during L1, 2 reset during 4th L1 cycle, 3 weight write on accept edge
  task automatic run_inf(input string tag, input int mode, input int hold);
    int lat;
    int wd;
    for (int i = 0; i < IN; i++) in_data[i*B +: B] = B'(xin[i]);
    chk({tag, "/in_ready"}, int'(in_ready), 1);
    if (mode == 3) begin
      wd = int'($urandom_range(0, 255)) - 128;
      w_wr_en = 1'b1;
      w_addr  = '0;
      w_data  = B'(wd);
      wm[0]   = wd;
    end
    model();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (mode == 1 && lat == 2) begin
        w_wr_en = 1'b1;
        w_addr  = AW'(1);
        w_data  = B'(5);
      end
      if (mode == 1 && lat == 3) w_wr_en = 1'b0;
      if (mode == 2 && lat == 3) reset_n = 1'b0;
      if (mode == 2 && lat == 4) begin
        chk({tag, "/busy_after_rst"}, int'(busy), 0);
        chk({tag, "/in_ready_after_rst"}, int'(in_ready), 1);
        reset_n = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    if (mode == 2) begin
      chk({tag, "/no_out_valid"}, int'(out_valid), 0);
      for (int a = 0; a < NW; a++) wm[a] = 0;
      return;
    end
    chk({tag, "/latency"}, lat, NW + 1);
    for (int k = 0; k < OUTN; k++) chk({tag, "/out"}, dut_out(k), exp_o[k]);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = (IN*B)'($urandom);
      @(negedge clk);
      chk({tag, "/hold_valid"}, int'(out_valid), 1);
      chk({tag, "/hold_in_ready"}, int'(in_ready), 0);
      for (int k = 0; k < OUTN; k++) chk({tag, "/hold_out"}, dut_out(k), exp_o[k]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/ready_again"}, int'(in_ready), 1);
    chk({tag, "/valid_dropped"}, int'(out_valid), 0);
  endtask

  task automatic load_xor();
    int tab [NW] = '{0, 1, 1, -1, 1, 1, 0, 1, -2};
    for (int a = 0; a < NW; a++) write_w(a, tab[a]);
  endtask

  initial begin
    for (int a = 0; a < NW; a++) wm[a] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset/in_ready", int'(in_ready), 1);
    chk("reset/busy", int'(busy), 0);
    chk("reset/out_valid", int'(out_valid), 0);
    chk("reset/out_data", int'(out_data), 0);

    load_xor();
    set_x(0, 0); run_inf("xor00", 0, 0);
    set_x(0, 1); run_inf("xor01", 0, 0);
    set_x(1, 0); run_inf("xor10", 0, 0);
    set_x(1, 1); run_inf("xor11", 0, 0);

    set_x(0, 1); run_inf("hold5", 0, 5);

    set_x(1, 0); run_inf("wr_in_l1", 1, 0);
    set_x(1, 0); run_inf("after_wr_in_l1", 0, 0);
    write_w(NW, 77);
    set_x(1, 1); run_inf("wr_oob", 0, 0);

    for (int a = 0; a < NW; a++) write_w(a, 127);
    set_x(127, 127); run_inf("sat_hi", 0, 0);
    for (int a = L1N; a < NW; a++) write_w(a, -128);
    set_x(127, 127); run_inf("sat_lo", 0, 0);

    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < NW; a++) write_w(a, int'($urandom_range(0, 255)) - 128);
      set_x(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      run_inf($sformatf("rand%0d", it), (it % 4 == 3) ? 3 : 0, int'($urandom_range(0, 2)));
    end

    load_xor();
    set_x(1, 1); run_inf("rst_mid", 2, 0);
    set_x(0, 1); run_inf("post_rst01", 0, 0);
    set_x(1, 0); run_inf("post_rst10", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mlp_infer.md
MLP_INFER -- requirements
Module: mlp_infer

Interface
REQ-001 SHALL have parameter IN_SIZE, default 2, number of input features.
REQ-002 SHALL have parameter HIDDEN_SIZE, default 2, number of hidden neurons.
REQ-003 SHALL have parameter OUT_SIZE, default 1, number of output neurons.
REQ-004 SHALL have parameter BITS_PER_WORD, default 8, signed width of inputs, weights, activations and outputs.
REQ-005 SHALL have parameter ACC_BITS, default 20, signed accumulator width; must be at least 2*BITS_PER_WORD+clog2(max(IN_SIZE,HIDDEN_SIZE)+1).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port w_wr_en, input, 1, weight write strobe.
REQ-009 SHALL have port w_addr, input, clog2(NW), weight index, where NW = HIDDEN_SIZE*(IN_SIZE+1) + OUT_SIZE*(HIDDEN_SIZE+1).
REQ-010 SHALL have port w_data, input, BITS_PER_WORD, signed weight value.
REQ-011 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, IN_SIZE*BITS_PER_WORD); feature i sits at [i*BITS_PER_WORD +: BITS_PER_WORD].
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, OUT_SIZE*BITS_PER_WORD); neuron k sits at [k*BITS_PER_WORD +: BITS_PER_WORD].
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL lay out weights as follows: layer-1 neuron j, term i at address j*(IN_SIZE+1)+i; layer-2 neuron k, term i at HIDDEN_SIZE*(IN_SIZE+1) + k*(HIDDEN_SIZE+1) + i; term i=0 is the bias.
REQ-015 SHALL commit a write at the clock edge where w_wr_en=1 only in IDLE and only if w_addr<NW; writes in any other state or to any other address are dropped.
REQ-016 SHALL implement an FSM with states IDLE -> L1 -> L2 -> HOLD -> IDLE; in_ready=1 only in IDLE.
REQ-017 SHALL capture in_data and go to L1 on in_valid&&in_ready; a weight write on that same edge is used by the inference.
REQ-018 SHALL perform exactly one signed BITS_PER_WORD x BITS_PER_WORD multiply-accumulate per cycle in L1 and L2, bias first: HIDDEN_SIZE*(IN_SIZE+1) cycles in L1, then OUT_SIZE*(HIDDEN_SIZE+1) cycles in L2.
REQ-019 SHALL saturate each neuron's accumulator to the signed BITS_PER_WORD range; hidden activation = max(0, saturated value).
REQ-020 SHALL raise out_valid exactly NW+1 edges after the accepting edge (10 with defaults).
REQ-021 SHALL hold out_data stable and out_valid=1 in HOLD until out_valid&&out_ready, then return to IDLE with in_ready=1 on the next cycle; back-to-back inputs are not overlapped.
REQ-022 SHALL ignore in_valid while busy; the accumulator must never carry across neurons or inferences.

Reset
REQ-023 SHALL, when reset_n=0 at an edge: go to IDLE; set out_valid=0, out_data=0, busy=0, in_ready=1 after release; clear all weights and the accumulator to 0.
REQ-024 SHALL abort any in-progress inference on reset mid-operation, with no out_valid pulse afterwards.

Configuration
REQ-025 SHALL, when macro MLP_OUT_RELU_EN is defined, apply ReLU to the saturated output neurons; when it is undefined, output neurons are linear (saturation only).

Verification
REQ-026 Bench SHALL load XOR weights (L1 {0,1,1},{-1,1,1}; L2 {0,1,-2}) and apply inputs (0,0),(0,1),(1,0),(1,1) -> outputs 0,1,1,0, each with out_valid 10 cycles after acceptance.
REQ-027 Bench SHALL set all weights to 127 and inputs to (127,127) -> out_data=127 (saturated); set L2 weights to -128 -> out_data=-128 without MLP_OUT_RELU_EN and 0 with it.
REQ-028 Bench SHALL hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> in_ready=1 on the next cycle.
REQ-029 Bench SHALL write w_addr=1 with value 5 during L1 -> the write is dropped and the result is unchanged; write w_addr=NW -> the write is ignored.
REQ-030 Bench SHALL assert reset_n=0 for one edge in the 4th L1 cycle -> busy=0, out_valid stays 0, all weights read back as 0 (XOR inputs give output 0).
